aud_recorder: RTL

Serial audio capture stage that sits between the codec's ADC serial interface and the SRAM write port inside the recorder/player datapath. It deserialises the left-channel 16-bit sample of each I2S frame and issues one single-cycle write strobe per sample with an incrementing SRAM word address. The record/pause/stop FSM drives it with single-cycle command pulses, and the 20-bit sample count it leaves behind bounds playback.

---
 rtl/aud_recorder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/aud_recorder.sv
`default_nettype none
// ============================================================================
// aud_recorder : I2S left-channel capture into sequential SRAM write strobes
// Revision     : 1.0
// ============================================================================
module aud_recorder #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [1:0]        o_state,
    output logic              o_full
);

    localparam int             CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_STORE = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                lrc_prev_q, lrc_prev_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                full_q, full_d;
    logic                w_fall;

    assign w_fall = lrc_prev_q & ~i_lrc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            lrc_prev_q <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lrc_prev_q <= lrc_prev_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lrc_prev_d = i_lrc;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        full_d     = full_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    full_d  = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_PAUSE: begin
                if (i_stop)
                    state_d = S_IDLE;
                else if (!i_pause && i_start)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                // The edge cycle's data bit is the I2S delay slot and is dropped.
                if (i_stop)
                    state_d = S_IDLE;
                else if (i_pause)
                    state_d = S_PAUSE;
                else if (w_fall) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_stop)
                    state_d = S_IDLE;
                else if (i_pause)
                    state_d = S_PAUSE;
                else begin
                    shift_d = {shift_q[DATA_W-2:0], i_data};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        data_d  = {shift_q[DATA_W-2:0], i_data};
                        valid_d = 1'b1;
                        state_d = S_STORE;
                    end
                end
            end
            S_STORE: begin
                // Commands seen here act only after the write and increment.
                if (addr_q == MAX_ADDR) begin
                    full_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (i_stop)
                        state_d = S_IDLE;
                    else if (i_pause)
                        state_d = S_PAUSE;
                    else
                        state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            S_WAIT, S_SHIFT, S_STORE: o_state = 2'd1;
            S_PAUSE:                  o_state = 2'd2;
            default:                  o_state = 2'd0;
        endcase
    end

    assign o_address = addr_q;
    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_full    = full_q;

endmodule
`default_nettype wire
